// File: rtl/fib_bcd_conv.sv
// Binary-to-packed-BCD converter for Fibonacci results: sequential double-dabble,
// one bit per clock, with valid/ready handshakes on both sides.
module fib_bcd_conv #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned DIGITS   = 10,
  localparam int unsigned NDW     = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  vld_in,
  output logic                  rdy_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [NDW-1:0]        ndig_out,
  output logic                  vld_out,
  input  logic                  rdy_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [BW-1:0]       bcd_acc;
  logic [BW-1:0]       bcd_adj_c;
  logic [IN_WIDTH-1:0] bin_sh;
  logic [CW-1:0]       bit_cnt;
  logic [NDW-1:0]      ndig_c;

  generate
    if (DIGITS * 10 < IN_WIDTH * 3 + 1) begin : g_digits_chk
      $error("fib_bcd_conv: DIGITS too small to hold 2^IN_WIDTH-1");
    end
  endgenerate

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj_c = bcd_acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  // Significant digits: highest nonzero digit index + 1, minimum of one.
  always_comb begin
    ndig_c = NDW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] != 4'd0) begin
        ndig_c = NDW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bcd_acc  <= '0;
      bin_sh   <= '0;
      bit_cnt  <= '0;
      bcd_out  <= '0;
      ndig_out <= '0;
      vld_out  <= 1'b0;
      rdy_in   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (vld_in && rdy_in) begin
            bin_sh  <= bin_in;
            bcd_acc <= '0;
            bit_cnt <= CW'(IN_WIDTH);
            rdy_in  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            bcd_acc <= {bcd_adj_c[BW-2:0], bin_sh[IN_WIDTH-1]};
            bin_sh  <= bin_sh << 1;
            bit_cnt <= bit_cnt - CW'(1);
          end else begin
            // Final digits are in bcd_acc; latch result and count together.
            bcd_out  <= bcd_acc;
            ndig_out <= ndig_c;
            vld_out  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (rdy_out) begin
            vld_out <= 1'b0;
            rdy_in  <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
